// File: rtl/blob_pkg.sv
// Shared types and constants for the blob bounding-box scanner.
package blob_pkg;

    localparam int BLOB_COORD_W = 10;
    // Box fields are held wider than any coordinate so min/max compares need no per-width struct.
    localparam int BLOB_BOX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STEP,
        ST_DONE
    } scan_state_t;

    typedef struct packed {
        logic [BLOB_BOX_W-1:0] x0;
        logic [BLOB_BOX_W-1:0] x1;
        logic [BLOB_BOX_W-1:0] y0;
        logic [BLOB_BOX_W-1:0] y1;
    } bbox_t;

endpackage

// File: rtl/scan_address_gen.sv
// Search-window latch and raster address stepping for the blob scanner.
module scan_address_gen
    import blob_pkg::*;
#(
    parameter int COORD_W = BLOB_COORD_W,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               advance_i,
    input  logic [COORD_W-1:0] win_x0_i,
    input  logic [COORD_W-1:0] win_x1_i,
    input  logic [COORD_W-1:0] win_y0_i,
    input  logic [COORD_W-1:0] win_y1_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o,
    output logic               invalid_o
);

    localparam logic [COORD_W:0] STRIDE = (COORD_W+1)'(STEP);

    logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q, x_q, y_q;
    logic [COORD_W-1:0] x0_d, x1_d, y0_d, y1_d, x_d, y_d;
    logic [COORD_W:0]   x_nxt, y_nxt;
    logic               x_wrap, y_wrap;

    // One extra bit keeps x+STEP from wrapping past the window edge near all-ones.
    always_comb begin
        x_nxt  = {1'b0, x_q} + STRIDE;
        y_nxt  = {1'b0, y_q} + STRIDE;
        x_wrap = x_nxt > {1'b0, x1_q};
        y_wrap = y_nxt > {1'b0, y1_q};
        x0_d   = x0_q;
        x1_d   = x1_q;
        y0_d   = y0_q;
        y1_d   = y1_q;
        x_d    = x_q;
        y_d    = y_q;
        if (load_i) begin
            x0_d = win_x0_i;
            x1_d = win_x1_i;
            y0_d = win_y0_i;
            y1_d = win_y1_i;
            x_d  = win_x0_i;
            y_d  = win_y0_i;
        end else if (advance_i) begin
            if (x_wrap) begin
                x_d = x0_q;
                y_d = y_nxt[COORD_W-1:0];
            end else begin
                x_d = x_nxt[COORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            x0_q <= x0_d;
            x1_q <= x1_d;
            y0_q <= y0_d;
            y1_q <= y1_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign last_o    = x_wrap && y_wrap;
    assign invalid_o = (win_x1_i < win_x0_i) || (win_y1_i < win_y0_i);

endmodule

// File: rtl/blob_bbox_scanner.sv
// Raster-scans a search window through pixel_cache and reports the set-pixel bounding box and count.
// Define BBOX_CENTROID_EN to add saturating sum_x/sum_y coordinate sums for centroid computation.
module blob_bbox_scanner
    import blob_pkg::*;
#(
    parameter int COORD_W   = BLOB_COORD_W,
    parameter int STEP      = 1,
    parameter int MIN_COUNT = 1,
    parameter int CNT_W     = 2 * COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] search_x0,
    input  logic [COORD_W-1:0] search_x1,
    input  logic [COORD_W-1:0] search_y0,
    input  logic [COORD_W-1:0] search_y1,
    output logic [COORD_W-1:0] bounding_x0,
    output logic [COORD_W-1:0] bounding_x1,
    output logic [COORD_W-1:0] bounding_y0,
    output logic [COORD_W-1:0] bounding_y1,
    output logic [CNT_W-1:0]   count,
    output logic               found,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               request,
    input  logic               pixel,
`ifdef BBOX_CENTROID_EN
    output logic [CNT_W-1:0]   sum_x,
    output logic [CNT_W-1:0]   sum_y,
`endif
    input  logic               ready
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

    scan_state_t            state_q;
    logic                   pix_q;
    logic [CNT_W-1:0]       cnt_q;
    bbox_t                  box_q;
    logic [BLOB_BOX_W-1:0]  x_ext, y_ext;
    logic                   addr_last, win_invalid, addr_load, addr_advance;

    assign addr_load    = (state_q == ST_IDLE) && start;
    assign addr_advance = (state_q == ST_STEP);
    assign x_ext        = BLOB_BOX_W'(x);
    assign y_ext        = BLOB_BOX_W'(y);

    scan_address_gen #(
        .COORD_W (COORD_W),
        .STEP    (STEP)
    ) u_addr (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (addr_load),
        .advance_i (addr_advance),
        .win_x0_i  (search_x0),
        .win_x1_i  (search_x1),
        .win_y0_i  (search_y0),
        .win_y1_i  (search_y1),
        .x_o       (x),
        .y_o       (y),
        .last_o    (addr_last),
        .invalid_o (win_invalid)
    );

`ifdef BBOX_CENTROID_EN
    logic [CNT_W-1:0] sx_q, sy_q, sx_sat, sy_sat;
    logic [CNT_W:0]   sx_add, sy_add;

    assign sx_add = {1'b0, sx_q} + (CNT_W+1)'(x);
    assign sy_add = {1'b0, sy_q} + (CNT_W+1)'(y);
    assign sx_sat = sx_add[CNT_W] ? '1 : sx_add[CNT_W-1:0];
    assign sy_sat = sy_add[CNT_W] ? '1 : sy_add[CNT_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            request     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pix_q       <= 1'b0;
            cnt_q       <= '0;
            box_q       <= '0;
            bounding_x0 <= '0;
            bounding_x1 <= '0;
            bounding_y0 <= '0;
            bounding_y1 <= '0;
            count       <= '0;
            found       <= 1'b0;
`ifdef BBOX_CENTROID_EN
            sx_q        <= '0;
            sy_q        <= '0;
            sum_x       <= '0;
            sum_y       <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q    <= '0;
                        box_q.x0 <= '1;
                        box_q.y0 <= '1;
                        box_q.x1 <= '0;
                        box_q.y1 <= '0;
`ifdef BBOX_CENTROID_EN
                        sx_q     <= '0;
                        sy_q     <= '0;
`endif
                        busy     <= 1'b1;
                        if (win_invalid) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_FETCH;
                            request <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (ready) begin
                        pix_q   <= pixel;
                        request <= 1'b0;
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (pix_q) begin
                        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                        if (x_ext < box_q.x0) box_q.x0 <= x_ext;
                        if (x_ext > box_q.x1) box_q.x1 <= x_ext;
                        if (y_ext < box_q.y0) box_q.y0 <= y_ext;
                        if (y_ext > box_q.y1) box_q.y1 <= y_ext;
`ifdef BBOX_CENTROID_EN
                        sx_q <= sx_sat;
                        sy_q <= sy_sat;
`endif
                    end
                    if (addr_last) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_FETCH;
                        request <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    count   <= cnt_q;
                    found   <= (cnt_q != '0) && (cnt_q >= MIN_CNT);
                    // An empty scan reports a zero box rather than the min/max seeds.
                    if (cnt_q == '0) begin
                        bounding_x0 <= '0;
                        bounding_x1 <= '0;
                        bounding_y0 <= '0;
                        bounding_y1 <= '0;
                    end else begin
                        bounding_x0 <= box_q.x0[COORD_W-1:0];
                        bounding_x1 <= box_q.x1[COORD_W-1:0];
                        bounding_y0 <= box_q.y0[COORD_W-1:0];
                        bounding_y1 <= box_q.y1[COORD_W-1:0];
                    end
`ifdef BBOX_CENTROID_EN
                    sum_x   <= sx_q;
                    sum_y   <= sy_q;
`endif
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_bbox_scanner.sv
// Bench for blob_bbox_scanner: a STEP=1 and a STEP=4 instance against a grid-walk reference model.
module tb_blob_bbox_scanner;

    localparam int CW = 10;
    localparam int NW = 2 * CW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [CW-1:0] wx0 = '0, wx1 = '0, wy0 = '0, wy1 = '0;
    logic          start_a [2] = '{1'b0, 1'b0};
    logic          ready_a [2] = '{1'b0, 1'b0};
    logic          pixel_a [2] = '{1'b0, 1'b0};
    logic          request_a [2], busy_a [2], done_a [2], found_a [2];
    logic [CW-1:0] x_a [2], y_a [2], bx0_a [2], bx1_a [2], by0_a [2], by1_a [2];
    logic [NW-1:0] cnt_a [2];
`ifdef BBOX_CENTROID_EN
    logic [NW-1:0] sx_a [2], sy_a [2];
`endif

    blob_bbox_scanner #(.COORD_W(CW), .STEP(1), .MIN_COUNT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_a[0]),
        .search_x0(wx0), .search_x1(wx1), .search_y0(wy0), .search_y1(wy1),
        .bounding_x0(bx0_a[0]), .bounding_x1(bx1_a[0]), .bounding_y0(by0_a[0]), .bounding_y1(by1_a[0]),
        .count(cnt_a[0]), .found(found_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .x(x_a[0]), .y(y_a[0]), .request(request_a[0]), .pixel(pixel_a[0]),
`ifdef BBOX_CENTROID_EN
        .sum_x(sx_a[0]), .sum_y(sy_a[0]),
`endif
        .ready(ready_a[0])
    );

    blob_bbox_scanner #(.COORD_W(CW), .STEP(4), .MIN_COUNT(3)) dut1 (
        .clk(clk), .reset(reset), .start(start_a[1]),
        .search_x0(wx0), .search_x1(wx1), .search_y0(wy0), .search_y1(wy1),
        .bounding_x0(bx0_a[1]), .bounding_x1(bx1_a[1]), .bounding_y0(by0_a[1]), .bounding_y1(by1_a[1]),
        .count(cnt_a[1]), .found(found_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .x(x_a[1]), .y(y_a[1]), .request(request_a[1]), .pixel(pixel_a[1]),
`ifdef BBOX_CENTROID_EN
        .sum_x(sx_a[1]), .sum_y(sy_a[1]),
`endif
        .ready(ready_a[1])
    );

    // Frame image and pixel_cache behaviour knobs (written by the main sequence only).
    bit img [64][64];
    bit tie_a [2]  = '{1'b0, 1'b0};
    int maxd_a [2] = '{0, 0};
    bit junk_a [2] = '{1'b0, 1'b0};
    int act_d = 0;

    // Responder bookkeeping (written by the responder only).
    int            reqn_a [2]   = '{0, 0};
    int            instab_a [2] = '{0, 0};
    int            wait_a [2]   = '{0, 0};
    logic          prev_a [2]   = '{1'b0, 1'b0};
    logic [CW-1:0] hx_a [2], hy_a [2];
    int            visit_q [$];

    int checks = 0;
    int failures = 0;

    // Reference results.
    int exp_n, exp_cnt, ex0, ex1, ey0, ey1, exp_found;
    int exp_vis [$];
`ifdef BBOX_CENTROID_EN
    longint exp_sx, exp_sy;
`endif

    function automatic bit px(input logic [CW-1:0] xx, input logic [CW-1:0] yy);
        if (xx < 64 && yy < 64) return img[yy][xx];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // pixel_cache model: optional random latency, optional spurious ready while idle.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (request_a[d] && !prev_a[d]) begin
                    reqn_a[d]++;
                    hx_a[d] = x_a[d];
                    hy_a[d] = y_a[d];
                    if (d == act_d) visit_q.push_back(int'(y_a[d]) * 1024 + int'(x_a[d]));
                    wait_a[d] = (maxd_a[d] > 0) ? int'($urandom_range(maxd_a[d], 0)) : 0;
                end else if (request_a[d] && (x_a[d] !== hx_a[d] || y_a[d] !== hy_a[d])) begin
                    instab_a[d]++;
                end
                prev_a[d] = request_a[d];
                if (tie_a[d]) begin
                    ready_a[d] = 1'b1;
                    pixel_a[d] = px(x_a[d], y_a[d]);
                end else if (request_a[d]) begin
                    if (wait_a[d] == 0) begin
                        ready_a[d] = 1'b1;
                        pixel_a[d] = px(x_a[d], y_a[d]);
                    end else begin
                        ready_a[d] = 1'b0;
                        pixel_a[d] = 1'($urandom % 2);
                        wait_a[d]--;
                    end
                end else begin
                    ready_a[d] = junk_a[d] ? 1'($urandom % 2) : 1'b0;
                    pixel_a[d] = 1'($urandom % 2);
                end
            end
        end
    end

    task automatic clear_img();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                img[r][c] = 1'b0;
    endtask

    task automatic fill_rect(input int ax0, input int ay0, input int ax1, input int ay1);
        for (int r = ay0; r <= ay1; r++)
            for (int c = ax0; c <= ax1; c++)
                img[r][c] = 1'b1;
    endtask

    // Walk the stride grid of the window directly and tally the set pixels.
    task automatic model(input int d, input int ax0, input int ax1, input int ay0, input int ay1);
        int st, mn, n, c, mnx, mxx, mny, mxy;
        st = (d == 0) ? 1 : 4;
        mn = (d == 0) ? 1 : 3;
        n = 0; c = 0;
        mnx = 1 << 30; mny = 1 << 30; mxx = -1; mxy = -1;
        exp_vis.delete();
`ifdef BBOX_CENTROID_EN
        exp_sx = 0; exp_sy = 0;
`endif
        if (ax1 >= ax0 && ay1 >= ay0) begin
            for (int yy = ay0; yy <= ay1; yy += st) begin
                for (int xx = ax0; xx <= ax1; xx += st) begin
                    n++;
                    exp_vis.push_back(yy * 1024 + xx);
                    if (img[yy][xx]) begin
                        c++;
                        if (xx < mnx) mnx = xx;
                        if (xx > mxx) mxx = xx;
                        if (yy < mny) mny = yy;
                        if (yy > mxy) mxy = yy;
`ifdef BBOX_CENTROID_EN
                        exp_sx += xx;
                        exp_sy += yy;
`endif
                    end
                end
            end
        end
        exp_n = n;
        exp_cnt = c;
        exp_found = (c > 0 && c >= mn) ? 1 : 0;
        if (c == 0) begin
            ex0 = 0; ex1 = 0; ey0 = 0; ey1 = 0;
        end else begin
            ex0 = mnx; ex1 = mxx; ey0 = mny; ey1 = mxy;
        end
    endtask

    task automatic run_scan(input int d, input int ax0, input int ax1, input int ay0, input int ay1,
                            input bit tie, input int maxd, input bit junk, input bit mid,
                            input bit chk_visit, input string tag);
        int k, dcyc, base_req, base_inst, base_vis, mism;
        bit seen;
        model(d, ax0, ax1, ay0, ay1);
        tie_a[d] = tie;
        maxd_a[d] = maxd;
        junk_a[d] = junk;
        act_d = d;
        @(negedge clk);
        base_req = reqn_a[d];
        base_inst = instab_a[d];
        base_vis = visit_q.size();
        wx0 = CW'(ax0); wx1 = CW'(ax1); wy0 = CW'(ay0); wy1 = CW'(ay1);
        start_a[d] = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start_a[d] = 1'b0;
        check({tag, "_busy"}, 32'(busy_a[d]), 1);
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (mid && i == 6) begin
                start_a[d] = 1'b1;
                wx0 = 0; wx1 = 2; wy0 = 0; wy1 = 1;
            end
            if (mid && i == 7) start_a[d] = 1'b0;
            if (done_a[d] === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (tie || maxd == 0)
            check({tag, "_latency"}, dcyc - k, (exp_n == 0) ? 1 : 2 * exp_n + 1);
        check({tag, "_x0"}, 32'(bx0_a[d]), ex0);
        check({tag, "_x1"}, 32'(bx1_a[d]), ex1);
        check({tag, "_y0"}, 32'(by0_a[d]), ey0);
        check({tag, "_y1"}, 32'(by1_a[d]), ey1);
        check({tag, "_count"}, 32'(cnt_a[d]), exp_cnt);
        check({tag, "_found"}, 32'(found_a[d]), exp_found);
        check({tag, "_busy_end"}, 32'(busy_a[d]), 0);
        check({tag, "_requests"}, reqn_a[d] - base_req, exp_n);
        check({tag, "_addr_stable"}, instab_a[d] - base_inst, 0);
`ifdef BBOX_CENTROID_EN
        check({tag, "_sum_x"}, 32'(sx_a[d]), 32'(exp_sx));
        check({tag, "_sum_y"}, 32'(sy_a[d]), 32'(exp_sy));
`endif
        if (chk_visit) begin
            mism = 0;
            check({tag, "_visit_len"}, visit_q.size() - base_vis, exp_vis.size());
            for (int i = 0; i < exp_vis.size() && base_vis + i < visit_q.size(); i++)
                if (visit_q[base_vis + i] != exp_vis[i]) mism++;
            check({tag, "_visit_addr"}, mism, 0);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_a[d]), 0);
        $display("scan %s dut=%0d win=(%0d,%0d)-(%0d,%0d) count=%0d box=%0d,%0d,%0d,%0d requests=%0d",
                 tag, d, ax0, ay0, ax1, ay1, cnt_a[d], bx0_a[d], bx1_a[d], by0_a[d], by1_a[d],
                 reqn_a[d] - base_req);
    endtask

    initial begin
        int rx0, rx1, ry0, ry1, tmp, nd;
        bit got;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_request", 32'(request_a[0]), 0);
        check("rst_done", 32'(done_a[0]), 0);
        check("rst_busy", 32'(busy_a[0]), 0);
        check("rst_bx0", 32'(bx0_a[0]), 0);
        check("rst_bx1", 32'(bx1_a[0]), 0);
        check("rst_by0", 32'(by0_a[0]), 0);
        check("rst_by1", 32'(by1_a[0]), 0);
        check("rst_count", 32'(cnt_a[0]), 0);
        check("rst_found", 32'(found_a[0]), 0);
        check("rst_x", 32'(x_a[0]), 0);
        check("rst_y", 32'(y_a[0]), 0);
        check("rst_request1", 32'(request_a[1]), 0);
        reset = 1'b1;

        clear_img();
        fill_rect(3, 4, 7, 9);
        run_scan(0, 0, 15, 0, 15, 1'b1, 0, 1'b0, 1'b0, 1'b0, "blob");
        run_scan(0, 0, 15, 0, 15, 1'b0, 5, 1'b1, 1'b0, 1'b0, "backpressure");
        run_scan(0, 0, 15, 0, 15, 1'b1, 0, 1'b0, 1'b1, 1'b0, "midstart");

        clear_img();
        run_scan(0, 2, 9, 3, 6, 1'b1, 0, 1'b0, 1'b0, 1'b0, "empty");
        run_scan(0, 5, 3, 0, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, "inv_x");
        run_scan(1, 0, 4, 7, 2, 1'b0, 3, 1'b1, 1'b0, 1'b0, "inv_y");

        img[10][10] = 1'b1;
        run_scan(1, 0, 10, 0, 10, 1'b1, 0, 1'b0, 1'b0, 1'b1, "stride");

        clear_img();
        img[0][0] = 1'b1;
        img[4][4] = 1'b1;
        run_scan(1, 0, 10, 0, 10, 1'b0, 0, 1'b1, 1'b0, 1'b1, "thr_below");
        img[0][8] = 1'b1;
        run_scan(1, 0, 10, 0, 10, 1'b0, 2, 1'b1, 1'b0, 1'b0, "thr_at");

        for (int r = 0; r < 8; r++) begin
            for (int yy = 0; yy < 64; yy++)
                for (int xx = 0; xx < 64; xx++)
                    img[yy][xx] = ($urandom % 5 == 0);
            rx0 = $urandom_range(20, 0); rx1 = rx0 + $urandom_range(10, 0);
            ry0 = $urandom_range(20, 0); ry1 = ry0 + $urandom_range(10, 0);
            if ($urandom % 6 == 0) begin
                tmp = rx0; rx0 = rx1; rx1 = tmp;
            end
            run_scan(r % 2, rx0, rx1, ry0, ry1, 1'b0, $urandom_range(5, 0), 1'b1, 1'b0, 1'b1,
                     $sformatf("rand%0d", r));
        end

        // Abort a scan mid-FETCH with reset.
        clear_img();
        fill_rect(3, 4, 7, 9);
        tie_a[0] = 1'b0; maxd_a[0] = 5; junk_a[0] = 1'b0;
        @(negedge clk);
        wx0 = 0; wx1 = 15; wy0 = 0; wy1 = 15;
        start_a[0] = 1'b1;
        @(posedge clk);
        #1 start_a[0] = 1'b0;
        got = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (request_a[0] === 1'b1) got = 1'b1;
        end
        check("rstmid_in_fetch", 32'(got), 1);
        #2 reset = 1'b0;
        #1;
        check("rstmid_request_async", 32'(request_a[0]), 0);
        check("rstmid_busy_async", 32'(busy_a[0]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a[0] === 1'b1) nd++;
        end
        check("rstmid_no_done", nd, 0);
        check("rstmid_idle_request", 32'(request_a[0]), 0);
        run_scan(0, 0, 15, 0, 15, 1'b1, 0, 1'b0, 1'b0, 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
